mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the word-wide data memory interface. Accepts byte/half/word load and store
//  requests from the CPU datapath, addressed in bytes and little-endian, and converts them into
//  word accesses on the memory port.
//  - The data memory has a combinational read and a single-cycle synchronous word write.
//  - Sub-word stores are therefore done as read-modify-write.
//  - Sits between the execute stage and datamemory; responses return to writeback.
// PARAMETERS
//  ADDR_W   8   word-index width driven to memory (2**ADDR_W words; 256 by default)
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  rst_n         in   1   synchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   unit can accept; transfer when req_valid && req_ready
//  req_write     in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
//  req_signed    in   1   loads only: sign-extend sub-word result
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1   response present; held until resp_ready
//  resp_ready    in   1   consumer accepts response
//  resp_rdata    out  32  load result, extended; 0 for stores and errors
//  resp_err      out  1   misaligned or reserved-size request; no memory access made
//  mem_address   out  32  word index: {zeros, addr[ADDR_W+1:2]}
//  mem_MemWrite  out  1   write strobe to memory
//  mem_MemRead   out  1   read qualifier to memory
//  mem_din       out  32  write word to memory
//  mem_dout      in   32  read word from memory (combinational, valid in same cycle as mem_address)
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, RESP.
//  - Reset:
//    - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//    - mem_address=0, mem_MemWrite=0, mem_MemRead=0, mem_din=0.
//    - rst_n low aborts any operation immediately. mem_MemWrite is gated by rst_n so no write
//      occurs on a reset edge.
//  - IDLE:
//    - req_ready=1.
//    - On transfer, latch addr, size, signed, wdata and write; compute alignment.
//    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11) -> RESP, err=1.
//    - Load or sub-word store -> READ. Word store -> WRITE.
//  - READ (1 cycle):
//    - mem_MemRead=1, mem_address=word index; sample mem_dout at end of cycle.
//    - Load: extract lane (byte lane addr[1:0], half lane addr[1]), zero- or sign-extend into
//      resp_rdata -> RESP.
//    - Store: merge wdata into sampled word at the lane -> WRITE.
//  - WRITE (1 cycle): mem_MemWrite=1, mem_din=merged word (or wdata for word store) -> RESP.
//  - RESP:
//    - resp_valid=1; outputs held stable.
//    - On resp_ready -> IDLE, resp_valid=0 next cycle.
//    - req_ready=0 in all states except IDLE; requests are never buffered.
//  - Latency, request accept to resp_valid, all with resp_ready=1:
//    - load 2 cycles; word store 2 cycles; sub-word store 3 cycles; misaligned 1 cycle.
//    - Throughput: one request per latency+1 cycles.
//  - mem_MemRead and mem_MemWrite are never both 1. mem_address is stable for the whole READ
//    and WRITE cycles.
//  - Address bits [31:ADDR_W+2] are ignored (wrap modulo memory size); this is not an error.
// STRUCTURE
//  - Shared package mem_pkg:
//    - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams.
//    - state encoding IDLE/READ/WRITE/RESP.
//    - function is_aligned(size, addr[1:0]).
//  - One combinational sub-module mem_lane_align:
//    - extract(word, addr[1:0], size, signed) -> rdata.
//    - merge(word, wdata, addr[1:0], size) -> din.
//    - The FSM and registers stay in mem_access_unit.
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> MemWrite pulse 1 cycle with
//     mem_address=4; load returns 0xDEADBEEF, err=0.
//  2. Memory word 4 = 0x11223344; store byte 0xAA @0x12 -> READ then WRITE, mem_din=0x11AA3344;
//     signed byte load @0x12 -> 0xFFFFFFAA, unsigned -> 0x000000AA.
//  3. Half load @0x11 and word load @0x12 -> resp_err=1, rdata=0, no MemRead/MemWrite,
//     resp after 1 cycle.
//  4. resp_ready held low 5 cycles -> resp_valid and resp_rdata stable; req_ready=0; a new
//     req_valid is not accepted.
//  5. rst_n low during the READ of a half store -> no MemWrite ever asserted; all outputs at
//     reset values next cycle; memory word unchanged.
//  6. Word store @0x400 with ADDR_W=8 -> mem_address=0 (wrap); a load @0x0 returns the stored
//     value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiator: access sizes, FSM
// state encoding and the alignment rule used to flag bad requests.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Reserved size (2'b11) is never aligned, so it reports as an error.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~off[0];
            SIZE_WORD: ok = (off == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering between a 32-bit memory word and a
// right-aligned sub-word: extraction for loads, merging for stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] rdata_o,
    output logic [31:0] din_o
);

    logic [4:0]  bit_off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign bit_off = {off_i, 3'b000};

    // Load path: pick the addressed lane and zero/sign-extend it.
    always_comb begin
        byte_v  = word_i[bit_off +: 8];
        half_v  = off_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o = word_i;
        case (size_i)
            SIZE_BYTE: rdata_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SIZE_HALF: rdata_o = {{16{signed_i & half_v[15]}}, half_v};
            default:   rdata_o = word_i;
        endcase
    end

    // Store path: overwrite only the addressed lane of the word read back.
    always_comb begin
        din_o = word_i;
        case (size_i)
            SIZE_BYTE: din_o[bit_off +: 8] = wdata_i[7:0];
            SIZE_HALF: begin
                if (off_i[1]) din_o[31:16] = wdata_i[15:0];
                else          din_o[15:0]  = wdata_i[15:0];
            end
            SIZE_WORD: din_o = wdata_i;
            default:   din_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-wide data memory with
// combinational read and synchronous write. Sub-word stores are done as
// read-modify-write.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where resp_valid && resp_ready. req_ready
// is high only in IDLE, and resp_valid with its data stays stable until taken.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [1:0]  dbg_state_o
);

    state_e              state_q, state_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;   // upper address bits wrap, so never stored
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                write_q, write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         din_q, din_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         lane_rdata, lane_din;

    mem_lane_align u_align (
        .word_i   (mem_dout),
        .wdata_i  (wdata_q),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .rdata_o  (lane_rdata),
        .din_o    (lane_din)
    );

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            din_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: IDLE -> (READ ->) (WRITE ->) RESP -> IDLE.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[ADDR_W+1:0];
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    din_d    = req_wdata;
                    rdata_d  = '0;
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (req_write && req_size == SIZE_WORD) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (write_q) begin
                    din_d   = lane_din;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = lane_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port outputs decoded from registered state; write strobe also gated by reset.
    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        resp_valid   = (state_q == ST_RESP);
        resp_rdata   = rdata_q;
        resp_err     = err_q;
        mem_MemRead  = (state_q == ST_READ);
        mem_MemWrite = (state_q == ST_WRITE) && rst_n;
        mem_address  = '0;
        mem_din      = '0;
        if (state_q == ST_READ || state_q == ST_WRITE) begin
            mem_address = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
        end
        if (state_q == ST_WRITE) begin
            mem_din = din_q;
        end
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory,
// a response scoreboard and a memory-write monitor.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int W = 37;  // {latency[3:0], err, rdata[31:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_MemWrite (mem_MemWrite),
        .mem_MemRead  (mem_MemRead),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [256];
    assign mem_dout = mem_arr[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_MemWrite) mem_arr[mem_address[7:0]] <= mem_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory port monitor ----------------
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_din = '0;
    always @(negedge clk) begin
        if (mem_MemWrite) begin
            n_wr++;
            last_wr_addr = mem_address;
            last_wr_din  = mem_din;
            check("strobe_exclusive", {31'b0, mem_MemRead}, 32'd0);
        end
        if (mem_MemRead) n_rd++;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic         prev_valid = 1'b0;
    int           first_cyc = 0;
    logic [W-1:0] sb_e;
    int           sb_a;
    always @(negedge clk) begin
        if (resp_valid && !prev_valid) first_cyc = cyc;
        prev_valid = resp_valid;
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got rdata %h err %0b expected no response", resp_rdata, resp_err);
            end else begin
                sb_e = exp_q.pop_front();
                sb_a = acc_q.pop_front();
                check("resp_rdata", resp_rdata, sb_e[31:0]);
                check("resp_err", {31'b0, resp_err}, {31'b0, sb_e[32]});
                check("resp_latency", 32'(first_cyc - sb_a), {28'b0, sb_e[36:33]});
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int t;
        logic [3:0] lat;
        lat        = exp_lat[3:0];
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_accept_timeout: got req_ready 0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back({lat, exp_err, exp_rdata});
        acc_q.push_back(cyc);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || resp_valid || !req_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'b0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"},   {31'b0, resp_err}, 32'd0);
        check({tag, "_mem_address"}, mem_address, 32'd0);
        check({tag, "_MemWrite"},   {31'b0, mem_MemWrite}, 32'd0);
        check({tag, "_MemRead"},    {31'b0, mem_MemRead}, 32'd0);
        check({tag, "_mem_din"},    mem_din, 32'd0);
        check({tag, "_state"},      32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    int wr0, rd0;
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: word store then word load
        wr0 = n_wr;
        issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        wait_idle();
        check("t1_write_pulses", 32'(n_wr - wr0), 32'd1);
        check("t1_write_addr", last_wr_addr, 32'd4);
        check("t1_write_data", last_wr_din, 32'hDEADBEEF);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // 2: sub-word read-modify-write and extended loads
        issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
        wait_idle();
        rd0 = n_rd;
        wr0 = n_wr;
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3);
        wait_idle();
        check("t2_rmw_reads", 32'(n_rd - rd0), 32'd1);
        check("t2_rmw_writes", 32'(n_wr - wr0), 32'd1);
        check("t2_rmw_addr", last_wr_addr, 32'd4);
        check("t2_rmw_din", last_wr_din, 32'h11AA3344);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h12, 32'h0, 32'h000000AA, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, 32'h00000011, 1'b0, 2);
        issue(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0, 32'h000011AA, 1'b0, 2);
        issue(1'b1, SIZE_HALF, 1'b0, 32'h10, 32'hFFFFBEEF, 32'h0, 1'b0, 3);
        issue(1'b0, SIZE_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        issue(1'b0, SIZE_HALF, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h11AABEEF, 1'b0, 2);

        // 3: misaligned and reserved-size requests
        wait_idle();
        rd0 = n_rd;
        wr0 = n_wr;
        issue(1'b0, SIZE_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, SIZE_HALF, 1'b0, 32'h13, 32'h0000FFFF, 32'h0, 1'b1, 1);
        wait_idle();
        check("t3_no_reads", 32'(n_rd - rd0), 32'd0);
        check("t3_no_writes", 32'(n_wr - wr0), 32'd0);

        // 4: back-pressure on the response
        resp_ready = 1'b0;
        wr0 = n_wr;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h11AABEEF, 1'b0, 2);
        for (int t = 0; t < 10 && !resp_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {31'b0, resp_valid}, 32'd1);
            check("t4_hold_rdata", resp_rdata, 32'h11AABEEF);
            check("t4_hold_req_ready", {31'b0, req_ready}, 32'd0);
            req_write = 1'b1;
            req_size  = SIZE_WORD;
            req_addr  = 32'h0C;
            req_wdata = 32'hBAD0BAD0;
            req_valid = 1'b1;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        check("t4_blocked_req_no_write", 32'(n_wr - wr0), 32'd0);

        // 5: reset during the read phase of a half store
        issue(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h55667788, 32'h0, 1'b0, 2);
        wait_idle();
        wr0 = n_wr;
        req_write = 1'b1;
        req_size  = SIZE_HALF;
        req_addr  = 32'h22;
        req_wdata = 32'h00001234;
        req_valid = 1'b1;
        @(negedge clk);
        check("t5_in_read", {31'b0, mem_MemRead}, 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_write", 32'(n_wr - wr0), 32'd0);
        check("t5_mem_unchanged", mem_arr[8], 32'h55667788);
        issue(1'b0, SIZE_HALF, 1'b1, 32'h22, 32'h0, 32'h00005566, 1'b0, 2);

        // 6: upper address bits wrap
        wait_idle();
        issue(1'b1, SIZE_WORD, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        wait_idle();
        check("t6_wrap_addr", last_wr_addr, 32'd0);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h410, 32'h0, 32'h11AABEEF, 1'b0, 2);

        wait_idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
